// File: rtl/icache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_ctrl_pkg
//  Brief    : Shared widths, FSM encoding and word-select helper for the
//             instruction-cache refill controller.
//  Revision : 1.0  initial release
// ============================================================================
package icache_refill_ctrl_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 4;
    localparam int OFFSET_W    = $clog2(BLOCK_WORDS * WORD_W / 8);
    localparam int BLKADDR_W   = ADDR_W - OFFSET_W;
    localparam int CNT_W       = $clog2(BLOCK_WORDS);
    localparam int LINE_W      = BLOCK_WORDS * WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_FILL   = 2'd2,
        ST_REPLAY = 2'd3
    } state_t;

    // Word 0 of a block sits in the least-significant bits.
    function automatic logic [WORD_W-1:0] select_word(
        input logic [LINE_W-1:0] line,
        input logic [CNT_W-1:0]  idx
    );
        return line[int'(idx) * WORD_W +: WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_ctrl_if
//  Brief    : Fetch, SRAM and instruction-memory signals of the refill
//             controller; master = controller side, slave = environment.
//  Revision : 1.0  initial release
// ============================================================================
interface icache_refill_ctrl_if;
    import icache_refill_ctrl_pkg::*;

    logic                 cpu_req;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [WORD_W-1:0]    cpu_instr;
    logic                 cpu_valid;
    logic                 cpu_stall;
    logic                 sram_ren;
    logic                 sram_wen;
    logic [BLKADDR_W-1:0] sram_block_addr;
    logic [LINE_W-1:0]    sram_wdata;
    logic                 sram_hit;
    logic [LINE_W-1:0]    sram_rdata;
    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_rvalid;
    logic [WORD_W-1:0]    mem_rdata;
    logic [31:0]          miss_count;

    modport master (
        input  cpu_req, cpu_addr, sram_hit, sram_rdata, mem_rvalid, mem_rdata,
        output cpu_instr, cpu_valid, cpu_stall, sram_ren, sram_wen,
               sram_block_addr, sram_wdata, mem_req, mem_addr, miss_count
    );

    modport slave (
        output cpu_req, cpu_addr, sram_hit, sram_rdata, mem_rvalid, mem_rdata,
        input  cpu_instr, cpu_valid, cpu_stall, sram_ren, sram_wen,
               sram_block_addr, sram_wdata, mem_req, mem_addr, miss_count
    );

endinterface
`default_nettype wire

// File: rtl/icache_fill_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fill_buffer
//  Brief    : Beat counter and word-indexed block assembly buffer for refills.
//  Revision : 1.0  initial release
// ============================================================================
module icache_fill_buffer
    import icache_refill_ctrl_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clear,
    input  wire logic              i_beat_valid,
    input  wire logic [WORD_W-1:0] i_beat_data,
    output logic      [CNT_W-1:0]  o_count,
    output logic                   o_last_beat,
    output logic      [LINE_W-1:0] o_line
);

    logic [CNT_W-1:0] r_count;

    // Counter wraps to 0 on the last beat because BLOCK_WORDS is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_beat_valid) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] r_word;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (i_beat_valid && (r_count == CNT_W'(gi))) begin
                    r_word <= i_beat_data;
                end
            end

            assign o_line[gi*WORD_W +: WORD_W] = r_word;
        end
    endgenerate

    assign o_count     = r_count;
    assign o_last_beat = (r_count == CNT_W'(BLOCK_WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_ctrl
//  Brief    : I-cache controller: zero-latency hits, beat-wise block refill
//             from instruction memory, SRAM fill and lookup replay.
//  Revision : 1.0  initial release
// ============================================================================
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    icache_refill_ctrl_if.master  bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BLKADDR_W-1:0]  r_blk_addr;
    logic [31:0]           r_miss_count;

    logic                  w_miss_inc;
    logic                  w_clear;
    logic                  w_beat;
    logic                  w_latch;
    logic [CNT_W-1:0]      w_count;
    logic                  w_last;
    logic [LINE_W-1:0]     w_line;
    logic [WORD_W-1:0]     w_sel_word;
    logic [BLKADDR_W-1:0]  w_req_blk;

    logic                  w_cpu_valid;
    logic                  w_cpu_stall;
    logic [WORD_W-1:0]     w_cpu_instr;
    logic                  w_sram_ren;
    logic                  w_sram_wen;
    logic [BLKADDR_W-1:0]  w_sram_block_addr;
    logic [LINE_W-1:0]     w_sram_wdata;
    logic                  w_mem_req;
    logic [ADDR_W-1:0]     w_mem_addr;

    icache_fill_buffer u_fill_buffer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_beat_valid (w_beat),
        .i_beat_data  (bus.mem_rdata),
        .o_count      (w_count),
        .o_last_beat  (w_last),
        .o_line       (w_line)
    );

    assign w_req_blk  = bus.cpu_addr[ADDR_W-1:OFFSET_W];
    assign w_sel_word = select_word(bus.sram_rdata, bus.cpu_addr[OFFSET_W-1:2]);

    // Every output stays at 0 while rst is high, even mid-refill.
    always_comb begin
        w_state_nxt       = r_state;
        w_miss_inc        = 1'b0;
        w_clear           = 1'b0;
        w_beat            = 1'b0;
        w_latch           = 1'b0;
        w_cpu_valid       = 1'b0;
        w_cpu_stall       = 1'b0;
        w_cpu_instr       = '0;
        w_sram_ren        = 1'b0;
        w_sram_wen        = 1'b0;
        w_sram_block_addr = '0;
        w_sram_wdata      = '0;
        w_mem_req         = 1'b0;
        w_mem_addr        = '0;
        if (!rst) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_sram_ren        = bus.cpu_req;
                    w_sram_block_addr = w_req_blk;
                    if (bus.cpu_req && bus.sram_hit) begin
                        w_cpu_valid = 1'b1;
                        w_cpu_instr = w_sel_word;
                    end else if (bus.cpu_req) begin
                        w_cpu_stall = 1'b1;
                        w_latch     = 1'b1;
                        w_clear     = 1'b1;
                        w_miss_inc  = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    w_cpu_stall = 1'b1;
                    w_mem_req   = 1'b1;
                    w_mem_addr  = {r_blk_addr, w_count, 2'b00};
                    w_beat      = bus.mem_rvalid;
                    if (bus.mem_rvalid && w_last) begin
                        w_state_nxt = ST_FILL;
                    end
                end
                ST_FILL: begin
                    w_cpu_stall       = 1'b1;
                    w_sram_wen        = 1'b1;
                    w_sram_block_addr = r_blk_addr;
                    w_sram_wdata      = w_line;
                    w_state_nxt       = ST_REPLAY;
                end
                ST_REPLAY: begin
                    w_sram_ren        = 1'b1;
                    w_sram_block_addr = r_blk_addr;
                    if (bus.sram_hit) begin
                        w_cpu_valid = 1'b1;
                        w_cpu_instr = w_sel_word;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // Fill did not stick: count it as a fresh miss and refetch.
                        w_cpu_stall = 1'b1;
                        w_clear     = 1'b1;
                        w_miss_inc  = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_blk_addr   <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_blk_addr <= w_req_blk;
            end
            if (w_miss_inc && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign bus.cpu_valid       = w_cpu_valid;
    assign bus.cpu_stall       = w_cpu_stall;
    assign bus.cpu_instr       = w_cpu_instr;
    assign bus.sram_ren        = w_sram_ren;
    assign bus.sram_wen        = w_sram_wen;
    assign bus.sram_block_addr = w_sram_block_addr;
    assign bus.sram_wdata      = w_sram_wdata;
    assign bus.mem_req         = w_mem_req;
    assign bus.mem_addr        = w_mem_addr;
    assign bus.miss_count      = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_refill_ctrl
//  Brief    : Directed self-checking bench with SRAM and memory models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_refill_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_refill_ctrl_if bus ();

    icache_refill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        force_miss;
    logic        sram_init;
    logic        spur;
    logic [31:0] spur_data;
    int          gap;
    int          wait_cnt;

    assign bus.cpu_req  = cpu_req;
    assign bus.cpu_addr = cpu_addr;

    // Memory contents: block b word w = 0xA0 + w + (b-1)*0x100
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hA0 + 32'(a[3:2]) + (((a >> 4) - 32'd1) << 8);
    endfunction

    // Small direct-mapped SRAM model with async read, sync write.
    logic [27:0]  tag_q [16];
    logic         vld_q [16];
    logic [127:0] dat_q [16];
    logic [3:0]   sidx;
    assign sidx         = bus.sram_block_addr[3:0];
    assign bus.sram_hit = vld_q[sidx] && (tag_q[sidx] == bus.sram_block_addr) && !force_miss;
    assign bus.sram_rdata = dat_q[sidx];

    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 16; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else if (bus.sram_wen) begin
            vld_q[sidx] <= 1'b1;
            tag_q[sidx] <= bus.sram_block_addr;
            dat_q[sidx] <= bus.sram_wdata;
        end
    end

    // Memory responder: rvalid after 'gap' idle cycles of a held request.
    always @(posedge clk) begin
        if (rst || !bus.mem_req || bus.mem_rvalid) wait_cnt <= 0;
        else                                       wait_cnt <= wait_cnt + 1;
    end
    assign bus.mem_rvalid = (bus.mem_req && (wait_cnt == gap)) || spur;
    assign bus.mem_rdata  = spur ? spur_data : mdata(bus.mem_addr);

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic        stall;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 32'h18, 1'b1, 32'hA2, 1'b0};
        vecs[1] = '{1'b1, 32'h1C, 1'b1, 32'hA3, 1'b0};
        vecs[2] = '{1'b0, 32'h18, 1'b0, 32'h00, 1'b0};
        vecs[3] = '{1'b1, 32'h14, 1'b1, 32'hA1, 1'b0};
        vecs[4] = '{1'b1, 32'h10, 1'b1, 32'hA0, 1'b0};

        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h10; gap = 0;
        spur = 1'b0; spur_data = '0; force_miss = 1'b0; sram_init = 1'b1;
        repeat (2) next_cycle();
        check("rst_stall",   bus.cpu_stall, 0);
        check("rst_valid",   bus.cpu_valid, 0);
        check("rst_ren",     bus.sram_ren, 0);
        check("rst_memreq",  bus.mem_req, 0);
        check("rst_misscnt", bus.miss_count, 0);

        // First miss at 0x10 with single-cycle memory
        sram_init = 1'b0; rst = 1'b0; #1;
        check("miss_stall",  bus.cpu_stall, 1);
        check("miss_valid",  bus.cpu_valid, 0);
        check("miss_ren",    bus.sram_ren, 1);
        check("miss_blk",    bus.sram_block_addr, 28'h1);
        next_cycle();
        check("miss_count1", bus.miss_count, 1);
        for (int k = 0; k < 4; k++) begin
            check("beat_memreq", bus.mem_req, 1);
            check("beat_addr",   bus.mem_addr, 32'h10 + 32'(4 * k));
            check("beat_stall",  bus.cpu_stall, 1);
            next_cycle();
        end
        check("fill_wen",   bus.sram_wen, 1);
        check("fill_ren",   bus.sram_ren, 0);
        check("fill_stall", bus.cpu_stall, 1);
        check("fill_wdata", bus.sram_wdata, 128'h000000A3_000000A2_000000A1_000000A0);
        next_cycle();
        check("replay_valid", bus.cpu_valid, 1);
        check("replay_instr", bus.cpu_instr, 32'hA0);
        check("replay_stall", bus.cpu_stall, 0);
        next_cycle();

        // Hits on the filled block
        for (int i = 0; i < 5; i++) begin
            cpu_req = vecs[i].req; cpu_addr = vecs[i].addr; #1;
            check("hit_valid",  bus.cpu_valid, vecs[i].valid);
            check("hit_instr",  bus.cpu_instr, vecs[i].instr);
            check("hit_stall",  bus.cpu_stall, vecs[i].stall);
            check("hit_memreq", bus.mem_req, 0);
            next_cycle();
        end
        check("hit_misscnt", bus.miss_count, 1);

        // Refill with 3 idle cycles before each beat
        gap = 3; cpu_req = 1'b1; cpu_addr = 32'h40; #1;
        check("gap_miss_stall", bus.cpu_stall, 1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w <= 3; w++) begin
                check("gap_addr",  bus.mem_addr, 32'h40 + 32'(4 * k));
                check("gap_stall", bus.cpu_stall, 1);
                check("gap_valid", bus.cpu_valid, 0);
                next_cycle();
            end
        end
        check("gap_fill_wdata", bus.sram_wdata, 128'h000003A3_000003A2_000003A1_000003A0);
        next_cycle();
        check("gap_replay_instr", bus.cpu_instr, 32'h3A0);
        check("gap_misscnt", bus.miss_count, 2);
        cpu_req = 1'b0; gap = 0;
        next_cycle();

        // Reset in the middle of a refill
        cpu_req = 1'b1; cpu_addr = 32'h80; #1;
        next_cycle();
        next_cycle();
        next_cycle();
        check("pre_rst_addr", bus.mem_addr, 32'h88);
        rst = 1'b1; #1;
        check("in_rst_memreq", bus.mem_req, 0);
        next_cycle();
        rst = 1'b0; cpu_req = 1'b0; #1;
        check("post_rst_memreq", bus.mem_req, 0);
        check("post_rst_stall",  bus.cpu_stall, 0);
        check("post_rst_misscnt", bus.miss_count, 0);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h80; #1;
        next_cycle();
        check("refetch_misscnt", bus.miss_count, 1);
        for (int k = 0; k < 4; k++) begin
            check("refetch_addr", bus.mem_addr, 32'h80 + 32'(4 * k));
            next_cycle();
        end
        check("refetch_wdata", bus.sram_wdata, 128'h000007A3_000007A2_000007A1_000007A0);
        next_cycle();
        check("refetch_instr", bus.cpu_instr, 32'h7A0);
        cpu_req = 1'b0;
        next_cycle();

        // Spurious rvalid while idle
        spur = 1'b1; spur_data = 32'hDEADBEEF; #1;
        check("spur_stall",  bus.cpu_stall, 0);
        check("spur_memreq", bus.mem_req, 0);
        next_cycle();
        spur = 1'b0; #1;
        check("spur_after_memreq", bus.mem_req, 0);
        check("spur_misscnt", bus.miss_count, 1);
        cpu_req = 1'b1; cpu_addr = 32'h84; #1;
        check("spur_hit_instr", bus.cpu_instr, 32'h7A1);
        next_cycle();

        // Replay that misses goes back to FETCH from beat 0
        cpu_addr = 32'hC8; #1;
        check("rm_miss_stall", bus.cpu_stall, 1);
        next_cycle();
        repeat (4) next_cycle();
        check("rm_fill_wen", bus.sram_wen, 1);
        next_cycle();
        force_miss = 1'b1; #1;
        check("rm_replay_stall", bus.cpu_stall, 1);
        check("rm_replay_valid", bus.cpu_valid, 0);
        check("rm_replay_ren",   bus.sram_ren, 1);
        next_cycle();
        force_miss = 1'b0; #1;
        check("rm_fetch_memreq", bus.mem_req, 1);
        check("rm_fetch_addr",   bus.mem_addr, 32'hC0);
        check("rm_misscnt",      bus.miss_count, 3);
        repeat (4) next_cycle();
        check("rm_wdata", bus.sram_wdata, 128'h00000BA3_00000BA2_00000BA1_00000BA0);
        next_cycle();
        check("rm_final_valid", bus.cpu_valid, 1);
        check("rm_final_instr", bus.cpu_instr, 32'hBA2);
        cpu_req = 1'b0;
        next_cycle();
        check("end_misscnt", bus.miss_count, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Instruction-cache controller between the fetch stage and the I-cache SRAM array (async tag/data read, sync write on the edge after memWen).
- Serves hits combinationally in the request cycle.
- On a miss, stalls fetch, pulls the block from instruction memory one word per beat, assembles it, writes it into the SRAM, then replays the lookup.

Parameters:
- ADDR_W, 32, byte-address width.
- WORD_W, 32, instruction/memory beat width.
- BLOCK_WORDS, 4, words per cache block (power of 2, >=2).
- OFFSET_W, log2(BLOCK_WORDS*WORD_W/8), byte-offset bits (4 at defaults).
- BLKADDR_W, ADDR_W-OFFSET_W, block-address width, equal to the SRAM blockAddr width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  ADDR_W  fetch byte address, word-aligned; held stable by fetch while cpu_stall=1.
- cpu_instr  out  WORD_W  fetched instruction.
- cpu_valid  out  1  cpu_instr valid this cycle.
- cpu_stall  out  1  fetch must hold its request.
- sram_ren  out  1  SRAM read enable.
- sram_wen  out  1  SRAM write enable (block fill).
- sram_block_addr  out  BLKADDR_W  {tag,index} to SRAM.
- sram_wdata  out  BLOCK_WORDS*WORD_W  fill block; word 0 in LSBs.
- sram_hit  in  1  SRAM async hit.
- sram_rdata  in  BLOCK_WORDS*WORD_W  SRAM async block data; word 0 in LSBs.
- mem_req  out  1  beat request to instruction memory.
- mem_addr  out  ADDR_W  beat byte address.
- mem_rvalid  in  1  beat data valid.
- mem_rdata  in  WORD_W  beat data.
- miss_count  out  32  saturating count of misses since reset.

Behaviour:
- States: IDLE, FETCH, FILL, REPLAY. Reset → IDLE, beat counter=0, miss_count=0, fill buffer zeroed, latched block address=0.
- All outputs are 0 in reset and whenever not driven below; reset takes priority over every event, including an in-flight refill.
- Word select: cpu_addr[OFFSET_W-1:2] picks word k of sram_rdata, i.e. bits [k*WORD_W +: WORD_W].
- IDLE:
  - sram_ren=cpu_req; sram_block_addr=cpu_addr[ADDR_W-1:OFFSET_W].
  - cpu_req=1 and sram_hit=1: cpu_valid=1, cpu_instr=selected word, cpu_stall=0. Zero-latency hit, stay IDLE.
  - cpu_req=1 and sram_hit=0: cpu_stall=1 in the same cycle, latch block address, beat counter=0, miss_count+=1 (saturate at all-ones), go FETCH.
  - cpu_req=0: no outputs asserted.
- FETCH:
  - cpu_stall=1; mem_req=1; mem_addr={latched block, counter, 2'b00}.
  - On mem_rvalid, store mem_rdata into buffer word[counter] and increment counter.
  - When mem_rvalid arrives with counter==BLOCK_WORDS-1, go FILL with counter wrapped to 0.
  - mem_req stays high across beats (one outstanding beat, memory may take any number of cycles).
  - mem_rvalid outside FETCH is ignored.
- FILL (exactly 1 cycle):
  - sram_wen=1, sram_ren=0, sram_block_addr=latched block, sram_wdata=buffer, cpu_stall=1 → REPLAY.
- REPLAY:
  - sram_ren=1, sram_block_addr=latched block, cpu_stall=0.
  - sram_hit=1: cpu_valid=1, cpu_instr=selected word → IDLE.
  - sram_hit=0 (protocol violation, e.g. fill lost): cpu_stall=1, cpu_valid=0, miss_count+=1, re-enter FETCH.
- Miss latency: 1 (detect) + N beat waits + 1 (FILL) + 1 (REPLAY); with single-cycle memory, miss→valid = BLOCK_WORDS+2 cycles after the miss cycle.
- sram_ren and sram_wen are never both 1.
- cpu_valid is never 1 while cpu_stall=1.
- Changing cpu_addr during a stall is undefined; the controller uses the latched block address and the current cpu_addr offset.

Decomposition:
- Shared package/constants header (alongside the existing cache constants): ADDR_W, WORD_W, BLOCK_WORDS, OFFSET_W, BLKADDR_W, state encoding (IDLE=0, FETCH=1, FILL=2, REPLAY=3).
- One natural sub-module, icache_fill_buffer: beat counter, word-indexed store, last-beat flag and clear.
- FSM, word mux and miss counter stay in the top.

Test Plan:
- Reset, then cpu_req=1 at 0x00000010 with SRAM miss → cpu_stall=1 same cycle; mem_addr 0x10, 0x14, 0x18, 0x1C on successive beats; miss_count=1.
- Memory returns 0xA0,0xA1,0xA2,0xA3 with 1-cycle latency → FILL cycle has sram_wen=1 and sram_wdata={0xA3,0xA2,0xA1,0xA0}; next cycle cpu_valid=1, cpu_instr=0xA0.
- Then cpu_req at 0x00000018 (now a hit) → cpu_valid=1, cpu_instr=0xA2 same cycle, no mem_req, miss_count stays 1.
- Refill with 3-cycle gaps between mem_rvalid beats → mem_addr holds each beat address until its rvalid; buffer correct; cpu_stall held throughout.
- rst=1 asserted mid-FETCH after 2 beats → next cycle IDLE, mem_req=0, counter=0, miss_count=0; a new miss refetches from beat 0.
- Spurious mem_rvalid in IDLE, and REPLAY with sram_hit forced 0 → IDLE ignores the rvalid; REPLAY returns to FETCH with miss_count incremented.
